dma_wr_master_arbiter: RTL
==========================

Name: dma_wr_master_arbiter

Overview:
- Shares the single Avalon-MM write master between two requesters.
  - Requester 0: write datapath engine, issuing bursts of buffered payload.
  - Requester 1: status/descriptor-update engine, issuing single-beat descriptor writebacks.
- Uses round-robin arbitration with the grant locked for a whole burst, so beats of different requesters never interleave.
- Sits between the write engines and the AVMM master port of the DMA.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, write data width.
- BE_W, 4, byte-enable width (DATA_W/8).
- BURST_W, 5, burstcount width (maximum burst 2^(BURST_W-1) = 16).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- r0_write_i  in  1  requester 0 write request / beat valid.
- r0_addr_i  in  ADDR_W  requester 0 burst start address.
- r0_data_i  in  DATA_W  requester 0 write data.
- r0_be_i  in  BE_W  requester 0 byte enables.
- r0_burstcount_i  in  BURST_W  requester 0 beats in burst.
- r0_waitreq_o  out  1  stall to requester 0.
- r1_write_i  in  1  requester 1 write request (single beat).
- r1_addr_i  in  ADDR_W  requester 1 address.
- r1_data_i  in  DATA_W  requester 1 data.
- r1_be_i  in  BE_W  requester 1 byte enables.
- r1_waitreq_o  out  1  stall to requester 1.
- avm_write_o  out  1  master write.
- avm_addr_o  out  ADDR_W  master address.
- avm_data_o  out  DATA_W  master write data.
- avm_be_o  out  BE_W  master byte enables.
- avm_burstcount_o  out  BURST_W  master burstcount (requester 1 path forces 1).
- avm_waitreq_i  in  1  slave waitrequest.
- busy_o  out  1  high whenever a grant is held.

Behaviour:
- Reset is synchronous and active-high on clk.
  - State goes to IDLE; last_grant goes to 1, so requester 0 wins the first tie; beat counter is cleared.
  - Outputs during reset: avm_write_o=0, busy_o=0, r0_waitreq_o=1, r1_waitreq_o=1.
- States: IDLE, GNT0, GNT1 (registered).
- IDLE:
  - Both waitreq outputs are 1 and avm_write_o=0.
  - Only r0_write_i high -> GNT0. Only r1_write_i high -> GNT1.
  - Both high -> grant the requester not equal to last_grant.
  - last_grant updates on entry to a GNTx state.
- Grant latency: request sampled in IDLE at cycle N; the granted requester is muxed onto the master from cycle N+1.
- GNTx datapath:
  - avm_* outputs are a combinational mux of requester x: avm_write_o = rx_write_i.
  - rx_waitreq_o = avm_waitreq_i; the other requester's waitreq is 1.
  - Beat accepted = avm_write_o & ~avm_waitreq_i.
- GNT0 burst tracking:
  - On the first accepted beat, load beats_left = r0_burstcount_i - 1; burstcount 0 is treated as 1.
  - Each later accepted beat decrements beats_left.
  - An accepted beat while beats_left==0 (including a single-beat burst) -> IDLE.
- GNT1: first accepted beat -> IDLE; avm_burstcount_o=1.
- Re-arbitration costs one IDLE cycle between grants; throughput loss is accepted.
- Requester deasserting write mid-burst: grant is held and waits for the remaining beats (Avalon rule); no timeout.
- Address, burstcount and be are taken as presented on each beat; the arbiter does no checking.
- busy_o = (state != IDLE).
- Reset mid-burst: immediate return to IDLE; the partial burst is abandoned and only a system reset recovers it.

Decomposition:
- Shared package dma_pkg holds:
  - state encodings IDLE=2'b00, GNT0=2'b01, GNT1=2'b10;
  - default widths ADDR_W, DATA_W, BURST_W.
- One natural sub-module: dma_rr_arb2, a 2-way round-robin picker.
  - Inputs: req[1:0], last_grant. Output: one-hot gnt. Purely combinational.
  - Beat counter and FSM stay in the top module.

Test Plan:
- r1 alone, addr=0x1000_001C, data=0x0000_00A5, be=4'b1100, avm_waitreq_i=0:
  - GNT1 entered one cycle later; one beat issued with avm_burstcount_o=1; back to IDLE.
  - r0_waitreq_o stays 1 throughout.
- r0 burst of 4, addr=0x2000_0000, waitreq pulsed high on beat 2 for 3 cycles:
  - exactly 4 beats accepted, in order, with data held during the stall; then IDLE.
- r0 and r1 requesting together from reset:
  - r0 granted first (4-beat burst), then r1; next simultaneous request goes to r0 again (alternation).
- r1 raises its request during an r0 burst of 16:
  - no r1 beat appears before all 16 r0 beats complete; r1_waitreq_o=1 for the whole burst.
- r0_burstcount_i=0: treated as 1 beat; grant released after the single accepted beat.
- reset asserted on beat 3 of an 8-beat burst:
  - next cycle avm_write_o=0, busy_o=0, both waitreq outputs 1; the next tie goes to r0.

Source files
------------

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared arbiter state encoding and default widths for the DMA write path
package dma_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int BURST_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_t;

endpackage

// File: rtl/dma_rr_arb2.sv
// rtl/dma_rr_arb2.sv - two-way round-robin picker; on a tie the requester
// that did not win last time is chosen
module dma_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/dma_wr_master_arbiter.sv
// rtl/dma_wr_master_arbiter.sv - shares one Avalon-MM write master between the
// burst datapath engine (r0) and the single-beat descriptor writeback engine (r1)
module dma_wr_master_arbiter #(
  parameter int ADDR_W  = dma_pkg::ADDR_W,
  parameter int DATA_W  = dma_pkg::DATA_W,
  parameter int BE_W    = DATA_W / 8,
  parameter int BURST_W = dma_pkg::BURST_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               r0_write_i,
  input  logic [ADDR_W-1:0]  r0_addr_i,
  input  logic [DATA_W-1:0]  r0_data_i,
  input  logic [BE_W-1:0]    r0_be_i,
  input  logic [BURST_W-1:0] r0_burstcount_i,
  output logic               r0_waitreq_o,
  input  logic               r1_write_i,
  input  logic [ADDR_W-1:0]  r1_addr_i,
  input  logic [DATA_W-1:0]  r1_data_i,
  input  logic [BE_W-1:0]    r1_be_i,
  output logic               r1_waitreq_o,
  output logic               avm_write_o,
  output logic [ADDR_W-1:0]  avm_addr_o,
  output logic [DATA_W-1:0]  avm_data_o,
  output logic [BE_W-1:0]    avm_be_o,
  output logic [BURST_W-1:0] avm_burstcount_o,
  input  logic               avm_waitreq_i,
  output logic               busy_o
);
  import dma_pkg::*;

  arb_state_t         state, state_nxt;
  logic               last_grant, last_grant_nxt;
  logic               in_burst, in_burst_nxt;
  logic [BURST_W-1:0] beats_left, beats_left_nxt;
  logic [BURST_W-1:0] first_left;
  logic [BURST_W-1:0] remaining;
  logic [1:0]         gnt;
  logic               accept;

  dma_rr_arb2 u_rr_arb2 (
    .req        ({r1_write_i, r0_write_i}),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  // A zero burstcount behaves as a single beat.
  assign first_left = (r0_burstcount_i == '0) ? '0 : r0_burstcount_i - BURST_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      in_burst   <= 1'b0;
      beats_left <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      in_burst   <= in_burst_nxt;
      beats_left <= beats_left_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    last_grant_nxt   = last_grant;
    in_burst_nxt     = in_burst;
    beats_left_nxt   = beats_left;
    remaining        = '0;
    accept           = 1'b0;
    avm_write_o      = 1'b0;
    avm_addr_o       = '0;
    avm_data_o       = '0;
    avm_be_o         = '0;
    avm_burstcount_o = '0;
    r0_waitreq_o     = 1'b1;
    r1_waitreq_o     = 1'b1;

    case (state)
      IDLE: begin
        if (gnt[0]) begin
          state_nxt      = GNT0;
          last_grant_nxt = 1'b0;
          in_burst_nxt   = 1'b0;
          beats_left_nxt = '0;
        end else if (gnt[1]) begin
          state_nxt      = GNT1;
          last_grant_nxt = 1'b1;
        end
      end
      GNT0: begin
        avm_write_o      = r0_write_i;
        avm_addr_o       = r0_addr_i;
        avm_data_o       = r0_data_i;
        avm_be_o         = r0_be_i;
        avm_burstcount_o = r0_burstcount_i;
        r0_waitreq_o     = avm_waitreq_i;
        accept           = r0_write_i & ~avm_waitreq_i;
        // beats_left holds the beats still owed after the last accepted one
        remaining = in_burst ? beats_left - BURST_W'(1) : first_left;
        if (accept) begin
          if (remaining == '0) begin
            state_nxt      = IDLE;
            in_burst_nxt   = 1'b0;
            beats_left_nxt = '0;
          end else begin
            in_burst_nxt   = 1'b1;
            beats_left_nxt = remaining;
          end
        end
      end
      GNT1: begin
        avm_write_o      = r1_write_i;
        avm_addr_o       = r1_addr_i;
        avm_data_o       = r1_data_i;
        avm_be_o         = r1_be_i;
        avm_burstcount_o = BURST_W'(1);
        r1_waitreq_o     = avm_waitreq_i;
        accept           = r1_write_i & ~avm_waitreq_i;
        if (accept) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (reset) begin
      avm_write_o  = 1'b0;
      r0_waitreq_o = 1'b1;
      r1_waitreq_o = 1'b1;
    end
  end

  assign busy_o = (state != IDLE) & ~reset;

endmodule
